cmd_rx: RTL and testbench

Serial command receiver for the LED command path. Deframes 8N1 UART bytes from an external host on `rx`, assembles pairs of bytes into 12-bit commands `{address[4:0], op[2:0], d[3:0]}`, and presents each command on `cmd_buf` with a one-cycle `new_cmd` strobe. It sits directly upstream of the LED manager, which consumes `new_cmd`/`cmd_buf` unchanged.

---
 rtl/cmd_rx_pkg.sv | 31 +++
 rtl/uart_rx_byte.sv | 107 ++++++++++
 rtl/cmd_rx.sv | 93 +++++++++
 tb/tb_cmd_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cmd_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmd_rx_pkg : shared LED command field widths, FSM encodings and helpers   |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
package cmd_rx_pkg;

  localparam int CMD_W        = 12;
  localparam int ADDR_W       = 5;
  localparam int OP_W         = 3;
  localparam int D_W          = 4;
  localparam int HDR_FLAG_BIT = 7;
  localparam int PAYLOAD_W    = 6;

  // Byte receiver states
  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  // Frame assembler states
  localparam logic [0:0] ASM_EXP_HDR  = 1'b0;
  localparam logic [0:0] ASM_EXP_DATA = 1'b1;

  function automatic logic is_header(input logic [7:0] b);
    return b[HDR_FLAG_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_byte : 8N1 byte deframer with start-glitch and break handling    |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module uart_rx_byte
  import cmd_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sync,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [2:0]       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [2:0]       bit_idx_q,    bit_idx_d;
  logic [7:0]       shreg_q,      shreg_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q,  frame_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_sync) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_sync, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_sync) begin
            byte_valid_d = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            // Low stop bit: hold off until the line returns high so a break
            // yields a single error.
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        if (rx_sync) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shreg_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: rtl/cmd_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmd_rx   : UART command receiver, pairs header/data bytes into commands  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module cmd_rx
  import cmd_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic             new_cmd,
  output logic [CMD_W-1:0] cmd_buf,
  output logic             frame_err,
  output logic             seq_err
);

  logic                 rx_meta_q, rx_sync_q;
  logic                 w_byte_valid;
  logic [7:0]           w_byte_data;

  logic [0:0]           asm_q,     asm_d;
  logic [PAYLOAD_W-1:0] hdr_q,     hdr_d;
  logic [CMD_W-1:0]     cmd_q,     cmd_d;
  logic                 new_cmd_q, new_cmd_d;
  logic                 seq_err_q, seq_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (clk),
    .rst        (rst),
    .rx_sync    (rx_sync_q),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .frame_err  (frame_err)
  );

  // Bit 6 of every byte is reserved; only the low payload bits are kept.
  always_comb begin
    asm_d     = asm_q;
    hdr_d     = hdr_q;
    cmd_d     = cmd_q;
    new_cmd_d = 1'b0;
    seq_err_d = 1'b0;
    if (w_byte_valid) begin
      if (is_header(w_byte_data)) begin
        hdr_d = w_byte_data[PAYLOAD_W-1:0];
        asm_d = ASM_EXP_DATA;
      end else if (asm_q == ASM_EXP_DATA) begin
        cmd_d     = {hdr_q, w_byte_data[PAYLOAD_W-1:0]};
        new_cmd_d = 1'b1;
        asm_d     = ASM_EXP_HDR;
      end else begin
        seq_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q     <= ASM_EXP_HDR;
      hdr_q     <= '0;
      cmd_q     <= '0;
      new_cmd_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      hdr_q     <= hdr_d;
      cmd_q     <= cmd_d;
      new_cmd_q <= new_cmd_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign new_cmd = new_cmd_q;
  assign cmd_buf = cmd_q;
  assign seq_err = seq_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cmd_rx : directed scenarios plus random byte streams vs. a byte model  |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_cmd_rx;

  localparam int c_CPB = 16;
  localparam int c_LAT = 2 + c_CPB / 2 + 9 * c_CPB + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        w_new_cmd;
  logic [11:0] w_cmd_buf;
  logic        w_frame_err;
  logic        w_seq_err;

  cmd_rx #(.CLKS_PER_BIT(c_CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .new_cmd   (w_new_cmd),
    .cmd_buf   (w_cmd_buf),
    .frame_err (w_frame_err),
    .seq_err   (w_seq_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: cumulative strobe counts, captured commands, over-wide pulses
  int          mon_ncmd = 0, mon_seq = 0, mon_ferr = 0, mon_wide = 0;
  logic [11:0] got_q[$];
  int          got_t[$];
  logic        prev_n = 1'b0, prev_s = 1'b0, prev_f = 1'b0;
  always @(negedge clk) begin
    if (w_new_cmd) begin
      mon_ncmd++;
      got_q.push_back(w_cmd_buf);
      got_t.push_back(cyc);
    end
    if (w_seq_err)   mon_seq++;
    if (w_frame_err) mon_ferr++;
    if ((w_new_cmd && prev_n) || (w_seq_err && prev_s) || (w_frame_err && prev_f))
      mon_wide++;
    prev_n = w_new_cmd;
    prev_s = w_seq_err;
    prev_f = w_frame_err;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-level assembler rules
  logic        m_pend = 1'b0;
  logic [5:0]  m_hdr  = '0;
  logic [11:0] m_buf  = '0;
  logic [11:0] exp_q[$];
  int          exp_ncmd = 0, exp_seq = 0, exp_ferr = 0;

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)   exp_ferr++;
    else if (b[7]) begin m_pend = 1'b1; m_hdr = b[5:0]; end
    else if (m_pend) begin
      m_buf  = {m_hdr, b[5:0]};
      m_pend = 1'b0;
      exp_q.push_back(m_buf);
      exp_ncmd++;
    end else exp_seq++;
  endtask

  task automatic model_reset();
    m_pend = 1'b0;
    m_buf  = '0;
  endtask

  // Line driver: caller is always #1 after a rising edge
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap_bits);
    drive(1'b0, c_CPB);
    for (int i = 0; i < 8; i++) drive(b[i], c_CPB);
    drive(stop_ok, c_CPB);
    drive(1'b1, gap_bits * c_CPB);
    model_byte(b, stop_ok);
  endtask

  task automatic check_phase(input string tag);
    drive(1'b1, 2 * c_CPB);
    check_eq({tag, "_ncmd"}, mon_ncmd, exp_ncmd);
    check_eq({tag, "_seq"},  mon_seq,  exp_seq);
    check_eq({tag, "_ferr"}, mon_ferr, exp_ferr);
    check_eq({tag, "_buf"},  {20'd0, w_cmd_buf}, {20'd0, m_buf});
  endtask

  initial begin
    int start2;
    int lat;
    logic [7:0] b;
    bit ok;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_new_cmd",   w_new_cmd,   0);
    check_eq("rst_cmd_buf",   w_cmd_buf,   0);
    check_eq("rst_frame_err", w_frame_err, 0);
    check_eq("rst_seq_err",   w_seq_err,   0);
    rst = 1'b0;
    drive(1'b1, 4);

    // Single command plus latency from start of second byte
    send_byte(8'h99, 1'b1, 1);
    start2 = cyc;
    send_byte(8'h13, 1'b1, 1);
    check_phase("single");
    lat = (got_t.size() > 0) ? got_t[got_t.size()-1] - start2 : -1;
    check_eq("single_latency", lat, c_LAT);

    // Orphan data byte, then a good frame
    send_byte(8'h13, 1'b1, 1);
    check_phase("orphan");
    send_byte(8'h99, 1'b1, 1);
    send_byte(8'h13, 1'b1, 1);
    check_phase("orphan_recover");

    // Header resync
    send_byte(8'h9F, 1'b1, 1);
    send_byte(8'h99, 1'b1, 1);
    send_byte(8'h13, 1'b1, 1);
    check_phase("resync");

    // Framing error on the header byte's stop bit; a prior header survives
    send_byte(8'h99, 1'b1, 1);
    send_byte(8'h99, 1'b0, 1);
    check_phase("ferr_hdr");
    send_byte(8'h13, 1'b1, 1);
    check_phase("ferr_recover");

    // Break: line held low for 40 bit times
    drive(1'b0, 40 * c_CPB);
    drive(1'b1, 2 * c_CPB);
    exp_ferr++;
    check_phase("break");

    // Start glitch
    drive(1'b0, 4);
    drive(1'b1, 2 * c_CPB);
    check_phase("glitch");
    send_byte(8'hC0, 1'b1, 1);
    send_byte(8'h3F, 1'b1, 1);
    check_phase("glitch_recover");

    // Reset in the middle of the data byte
    send_byte(8'h99, 1'b1, 1);
    drive(1'b0, c_CPB);
    for (int i = 0; i < 4; i++) drive(1'b1 & (8'h13 >> i), c_CPB);
    rst = 1'b1;
    drive(1'b1, 1);
    rst = 1'b0;
    check_eq("midrst_new_cmd", w_new_cmd, 0);
    check_eq("midrst_cmd_buf", w_cmd_buf, 0);
    check_eq("midrst_seq_err", w_seq_err, 0);
    model_reset();
    drive(1'b1, 10 * c_CPB);
    check_phase("midrst");
    send_byte(8'h99, 1'b1, 1);
    send_byte(8'h13, 1'b1, 1);
    check_phase("midrst_recover");

    // Random byte stream
    for (int n = 0; n < 40; n++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 9) != 0);
      send_byte(b, ok, $urandom_range(1, 3));
    end
    check_phase("random");

    check_eq("cmd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("cmd_%0d", i), {20'd0, got_q[i]}, {20'd0, exp_q[i]});
    check_eq("pulse_width", mon_wide, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
